// File: rtl/inst_enc_i.sv
// I-type / COP0 instruction encoder feeding a small output FIFO.
// Optional TLB ops (TLBWI, TLBP) are enabled by defining INST_ENC_TLB_EN.

package inst_enc_pkg;
    localparam logic [7:0] OP_INVAILD = 8'd0;
    localparam logic [7:0] OP_ADD     = 8'd1;
    localparam logic [7:0] OP_SLT     = 8'd2;
    localparam logic [7:0] OP_AND     = 8'd3;
    localparam logic [7:0] OP_OR      = 8'd4;
    localparam logic [7:0] OP_XOR     = 8'd5;
    localparam logic [7:0] OP_LU      = 8'd6;
    localparam logic [7:0] OP_BEQ     = 8'd7;
    localparam logic [7:0] OP_BNE     = 8'd8;
    localparam logic [7:0] OP_BLEZ    = 8'd9;
    localparam logic [7:0] OP_BGTZ    = 8'd10;
    localparam logic [7:0] OP_BLTZ    = 8'd11;
    localparam logic [7:0] OP_BGEZ    = 8'd12;
    localparam logic [7:0] OP_BLTZAL  = 8'd13;
    localparam logic [7:0] OP_BGEZAL  = 8'd14;
    localparam logic [7:0] OP_LB      = 8'd15;
    localparam logic [7:0] OP_LH      = 8'd16;
    localparam logic [7:0] OP_LW      = 8'd17;
    localparam logic [7:0] OP_LWL     = 8'd18;
    localparam logic [7:0] OP_LWR     = 8'd19;
    localparam logic [7:0] OP_SB      = 8'd20;
    localparam logic [7:0] OP_SH      = 8'd21;
    localparam logic [7:0] OP_SW      = 8'd22;
    localparam logic [7:0] OP_SWL     = 8'd23;
    localparam logic [7:0] OP_SWR     = 8'd24;
    localparam logic [7:0] OP_MFC0    = 8'd25;
    localparam logic [7:0] OP_MTC0    = 8'd26;
    localparam logic [7:0] OP_ERET    = 8'd27;
    localparam logic [7:0] OP_WAIT    = 8'd28;
    localparam logic [7:0] OP_TLBWI   = 8'd29;
    localparam logic [7:0] OP_TLBP    = 8'd30;
    localparam logic [7:0] OP_CACHE   = 8'd31;
    localparam logic [7:0] OP_PREF    = 8'd32;
endpackage

// Generic circular FIFO with extra-MSB pointers and synchronous flush.
// Latency: a word pushed at edge N is visible at the head after edge N.
// Backpressure: push_rdy = !full from state only; no push while full even if popping.
module inst_enc_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    output logic                     push_rdy,
    output logic                     pop_vld,
    input  logic                     pop_rdy,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         full;
    logic         empty;
    logic         do_push;
    logic         do_pop;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign push_rdy = !full;
    assign pop_vld  = !empty;
    assign pop_dat  = mem[rd_ptr[AW-1:0]];
    assign count    = wr_ptr - rd_ptr;

    // Flush wins over both sides, so a same-cycle push is dropped.
    assign do_push = push_vld && !full && !flush;
    assign do_pop  = pop_rdy && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end
endmodule

// Encodes decoded I-type/COP0 ops into MIPS words and queues them.
// Latency: 1 cycle from accept to out_valid when the FIFO was empty.
// Backpressure: in_ready = !full (state only); unencodable ops are accepted and dropped.
module inst_enc_i
    import inst_enc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               op,
    input  logic [4:0]               reg_s,
    input  logic [4:0]               reg_t,
    input  logic [15:0]              immediate,
    input  logic                     flag_unsigned,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              inst,
    output logic                     err,
    output logic [7:0]               err_cnt,
    output logic [$clog2(DEPTH):0]   count
);
    logic [5:0]  enc_opc;
    logic [4:0]  enc_rs;
    logic [4:0]  enc_rt;
    logic [15:0] enc_imm;
    logic        enc_fixed;
    logic [31:0] fixed_word;
    logic        enc_ok;
    logic [31:0] enc_word;
    logic        accept;

    always_comb begin
        enc_opc    = 6'h00;
        enc_rs     = reg_s;
        enc_rt     = reg_t;
        enc_imm    = immediate;
        enc_fixed  = 1'b0;
        fixed_word = 32'h0;
        enc_ok     = 1'b1;
        case (op)
            OP_ADD:    enc_opc = flag_unsigned ? 6'h09 : 6'h08;
            OP_SLT:    enc_opc = flag_unsigned ? 6'h0b : 6'h0a;
            OP_LB:     enc_opc = flag_unsigned ? 6'h24 : 6'h20;
            OP_LH:     enc_opc = flag_unsigned ? 6'h25 : 6'h21;
            OP_AND:    enc_opc = 6'h0c;
            OP_OR:     enc_opc = 6'h0d;
            OP_XOR:    enc_opc = 6'h0e;
            OP_BEQ:    enc_opc = 6'h04;
            OP_BNE:    enc_opc = 6'h05;
            OP_LW:     enc_opc = 6'h23;
            OP_LWL:    enc_opc = 6'h22;
            OP_LWR:    enc_opc = 6'h26;
            OP_SB:     enc_opc = 6'h28;
            OP_SH:     enc_opc = 6'h29;
            OP_SW:     enc_opc = 6'h2b;
            OP_SWL:    enc_opc = 6'h2a;
            OP_SWR:    enc_opc = 6'h2e;
            OP_CACHE:  enc_opc = 6'h2f;
            OP_PREF:   enc_opc = 6'h33;
            OP_BLEZ: begin
                enc_opc = 6'h06;
                enc_rt  = 5'h00;
            end
            OP_BGTZ: begin
                enc_opc = 6'h07;
                enc_rt  = 5'h00;
            end
            OP_LU: begin
                enc_opc = 6'h0f;
                enc_rs  = 5'h00;
            end
            // REGIMM: the rt field selects the branch flavour.
            OP_BLTZ: begin
                enc_opc = 6'h01;
                enc_rt  = 5'h00;
            end
            OP_BGEZ: begin
                enc_opc = 6'h01;
                enc_rt  = 5'h01;
            end
            OP_BLTZAL: begin
                enc_opc = 6'h01;
                enc_rt  = 5'h10;
            end
            OP_BGEZAL: begin
                enc_opc = 6'h01;
                enc_rt  = 5'h11;
            end
            OP_MFC0: begin
                enc_opc = 6'h10;
                enc_rs  = 5'h00;
            end
            OP_MTC0: begin
                enc_opc = 6'h10;
                enc_rs  = 5'h04;
            end
            OP_ERET: begin
                enc_fixed  = 1'b1;
                fixed_word = 32'h4200_0018;
            end
            OP_WAIT: begin
                enc_fixed  = 1'b1;
                fixed_word = 32'h4200_0020;
            end
`ifdef INST_ENC_TLB_EN
            OP_TLBWI: begin
                enc_fixed  = 1'b1;
                fixed_word = 32'h4200_0002;
            end
            OP_TLBP: begin
                enc_fixed  = 1'b1;
                fixed_word = 32'h4200_0008;
            end
`endif
            default:   enc_ok = 1'b0;
        endcase
        enc_word = enc_fixed ? fixed_word : {enc_opc, enc_rs, enc_rt, enc_imm};
    end

    assign accept = in_valid && in_ready;

    inst_enc_fifo #(
        .W     (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push_vld (in_valid && enc_ok),
        .push_dat (enc_word),
        .push_rdy (in_ready),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (inst),
        .count    (count)
    );

    // Error tracking ignores flush: a bad op accepted during flush still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= 8'h00;
        end else begin
            err <= accept && !enc_ok;
            if (accept && !enc_ok && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'h01;
            end
        end
    end
endmodule

// File: doc/inst_enc_i.md
# inst_enc_i

I-type and COP0 instruction encoder with a buffered valid/ready front end. It takes a decoded operation in the stage_id form (`OP_*` code from defs.v, reg_s, reg_t, immediate, flag_unsigned) and produces the 32-bit MIPS instruction word, queued in a small FIFO. It is the inverse of the ID-stage I-type decoder. It sits in the debug/self-test path, injecting assembled instructions toward instruction fetch.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous FIFO clear.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- op  in  8  `OP_*` code.
- reg_s  in  5  rs field.
- reg_t  in  5  rt field.
- immediate  in  16  imm field.
- flag_unsigned  in  1  selects the unsigned opcode variant.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- inst  out  32  encoded word at FIFO head.
- err  out  1  one-cycle pulse: last accepted op was unencodable.
- err_cnt  out  8  saturating count of err pulses.
- count  out  log2(DEPTH)+1  FIFO occupancy.

## Operation
- Encoding is combinational from the inputs. The result is written into the FIFO on handshake. Fields are placed as inst[31:26]=opcode, [25:21]=rs, [20:16]=rt, [15:0]=imm unless noted.
- OP_ADD: opcode 0x09 if unsigned, else 0x08. OP_SLT: 0x0b if unsigned, else 0x0a. OP_LB: 0x24 if unsigned, else 0x20. OP_LH: 0x25 if unsigned, else 0x21.
- OP_AND 0x0c, OP_OR 0x0d, OP_XOR 0x0e, OP_BEQ 0x04, OP_BNE 0x05, OP_LW 0x23, OP_LWL 0x22, OP_LWR 0x26, OP_SB 0x28, OP_SH 0x29, OP_SW 0x2b, OP_SWL 0x2a, OP_SWR 0x2e, OP_CACHE 0x2f, OP_PREF 0x33.
- flag_unsigned is ignored for all ops except ADD, SLT, LB and LH.
- OP_BLEZ 0x06 and OP_BGTZ 0x07: rt forced to 0.
- OP_LU 0x0f: rs forced to 0.
- REGIMM (opcode 0x01): rt is forced to 0x00 for OP_BLTZ, 0x01 for OP_BGEZ, 0x10 for OP_BLTZAL, 0x11 for OP_BGEZAL.
- OP_MFC0: 0x10 with rs=0x00. OP_MTC0: 0x10 with rs=0x04. For both, rt and imm are passed through.
- OP_ERET → 0x42000018. OP_WAIT → 0x42000020. All fields are fixed.
- Any other op, including OP_INVAILD, is invalid:
  - the handshake still completes;
  - nothing is written to the FIFO;
  - err pulses high the next cycle;
  - err_cnt increments, saturating at 0xFF.
- FIFO: circular buffer with read/write pointers one bit wider than the index. Full when the index bits are equal and the MSBs differ. Empty when the pointers are equal.
- in_ready = !full. There is no bypass: a push into a full FIFO is refused even if a pop occurs in the same cycle.
- Push and pop in the same cycle (not full, not empty): count is unchanged and both pointers advance.
- flush: both pointers and count are cleared. Flush takes priority over push and pop in the same cycle. A request accepted in that cycle is discarded. err and err_cnt still respond to an invalid op accepted in that cycle.

## Timing
- Reset values: in_ready=1, out_valid=0, inst=0, err=0, err_cnt=0, count=0, pointers=0.
- Latency is 1 cycle: a valid op accepted at edge N has out_valid=1 and inst stable after edge N, provided the FIFO was empty.
- inst is driven from the head storage. It stays stable while out_valid && !out_ready.
- out_valid = !empty. in_ready and count are registered-state derived only, with no combinational path from out_ready.
- err is registered and asserts for the one cycle following the accept edge.
- Asserting rst_n low mid-operation immediately clears all state, regardless of the clock. Exit from reset is synchronous to clk.

## Configuration
- INST_ENC_TLB_EN defined: OP_TLBWI → 0x42000002 and OP_TLBP → 0x42000008.
- INST_ENC_TLB_EN undefined: OP_TLBWI and OP_TLBP are invalid ops (err pulse, no FIFO write).

## Test plan
- OP_ADD, unsigned=1, rs=3, rt=5, imm=0x1234 → inst=0x24651234 one cycle after accept. Same with unsigned=0 → 0x20651234.
- OP_LU, rs=7, rt=2, imm=0x8000 → 0x3C028000 (rs forced 0). OP_BGEZAL, rs=4, rt=0, imm=0xFFFF → 0x0491FFFF.
- OP_ERET → 0x42000018. OP_MTC0, rt=9, imm=0x0060 → 0x40890060.
- Five back-to-back pushes with out_ready=0:
  - in_ready falls after the 4th push and count=4;
  - the 5th push is not accepted;
  - one pop → in_ready=1 the next cycle, and the words drain in order.
- OP_TLBWI with INST_ENC_TLB_EN undefined → err=1 for one cycle, err_cnt=1, out_valid stays 0. With the macro defined → 0x42000002.
- Flush and reset:
  - Fill 3 entries, then assert flush together with a valid push → count=0 and out_valid=0 next cycle.
  - Separately, drop rst_n mid-drain → all outputs at reset values before the next edge.
